instruction_fetch_controller: RTL

Sequences reads from the synchronous instruction memory on behalf of the decode stage. Owns the fetch PC, issues one read per cycle subject to buffer credit, and captures each one-cycle-latency response into a small prefetch FIFO. Presents instructions to decode with a valid/ready handshake, and handles start, halt and PC redirects (branch/jump/trap) with flush of stale fetches. Sits between the PC/control logic and `instructionMemory`.

---
 rtl/instr_mem_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch_controller.sv | 117 +++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and types for the instruction fetch path
package instr_mem_pkg;

  localparam logic [31:0] IMEM_BOOT_ADDRESS    = 32'h0100_0000;
  localparam logic [31:0] IMEM_BASE_ADDRESS    = 32'h0100_0000;
  localparam int          IMEM_SIZE_WORDS      = 1024;
  localparam int          IMEM_FIFO_DEPTH      = 4;
  localparam logic [31:0] IMEM_NOP_INSTRUCTION = 32'h1111_1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  // Window end is formed in 33 bits so a window touching the top of memory cannot wrap.
  function automatic logic pc_outside_window(input logic [31:0] pc,
                                             input logic [31:0] base,
                                             input int unsigned words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(words) << 2);
    return (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush, async active-low reset
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - fetch PC sequencing, credit-gated reads, prefetch to decode
module instruction_fetch_controller
  import instr_mem_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS    = IMEM_BOOT_ADDRESS,
  parameter logic [31:0] BASE_ADDRESS    = IMEM_BASE_ADDRESS,
  parameter int          MEM_SIZE        = IMEM_SIZE_WORDS,
  parameter int          FIFO_DEPTH      = IMEM_FIFO_DEPTH,
  parameter logic [31:0] NOP_INSTRUCTION = IMEM_NOP_INSTRUCTION
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        halt,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        imemReadEnable,
  output logic [31:0] imemAddress,
  input  logic [31:0] imemInstruction,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outInstruction,
  output logic [31:0] outPc,
  output logic        outFault,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          pending;
  logic          issue;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata;
  fetch_entry_t  fifo_head;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start && !halt) state_next = ST_FETCH;
      ST_FETCH:  if (halt)           state_next = ST_HALTED;
      ST_HALTED: if (start && !halt) state_next = ST_FETCH;
      default:                       state_next = ST_IDLE;
    endcase
    // A redirect holds the state, but a halt arriving with it still takes effect.
    if (redirectValid && state_next == ST_FETCH) state_next = state;
  end

  always_comb begin
    // Credit uses occupancy at cycle start; a same-cycle pop does not free a slot.
    issue          = (state == ST_FETCH) && !redirectValid &&
                     (int'(fifo_count) + int'(pending) < FIFO_DEPTH);
    fifo_push      = pending && !redirectValid;
    outValid       = !fifo_empty && !redirectValid;
    fifo_pop       = outValid && outReady;
    outInstruction = fifo_empty ? NOP_INSTRUCTION : fifo_head.instr;
    outPc          = fifo_empty ? 32'h0 : fifo_head.pc;
    outFault       = !fifo_empty && fifo_head.fault;
    imemReadEnable = issue;
    imemAddress    = fetch_pc;
    busy           = (state == ST_FETCH) || pending || !fifo_empty;
  end

  assign fifo_wdata = '{instr: imemInstruction,
                        pc:    pending_pc,
                        fault: pc_outside_window(pending_pc, BASE_ADDRESS, MEM_SIZE)};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetch_pc   <= BOOT_ADDRESS;
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (redirectValid) begin
      fetch_pc <= redirectTarget & 32'hFFFF_FFFC;
      pending  <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetN),
    .flush     (redirectValid),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (resetN) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule
